fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter sharing one synchronous FIFO among NUM_REQ producers. Each producer has a valid/ready handshake. The arbiter grants one owner at a time for a burst of up to MAX_BURST beats and drives the FIFO's write enable and write data directly. It sits immediately upstream of the FIFO's write port, in the same clock domain, and consumes the FIFO's full flag as backpressure.

---
 rtl/fifo_wr_arbiter_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_wr_arbiter_rr_picker.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter: state encoding
// and the grant-id width helper.
package fifo_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  typedef enum logic {
    IDLE = ST_IDLE,
    OWN  = ST_OWN
  } arb_state_t;

  // A single producer still needs a one-bit id field.
  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port signals seen by the arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);

  localparam int GW = gid_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          grant_valid;
  logic [GW-1:0]                 grant_id;

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
  );

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_data_in, grant_valid, grant_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests so last_grant+1 sits at
// bit 0, priority-encode the lowest set bit, then rotate the index back.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int GW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic               found,
  output logic [GW-1:0]      winner
);

  logic [NUM_REQ-1:0] rot;
  int                 start_idx;
  int                 off;

  always_comb begin
    rot       = '0;
    off       = 0;
    start_idx = (int'(last_grant) + 1) % NUM_REQ;
    for (int k = 0; k < NUM_REQ; k++) begin
      rot[k] = req[(start_idx + k) % NUM_REQ];
    end
    found = |rot;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = k;
    end
    winner = GW'((start_idx + off) % NUM_REQ);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one producer at a time for bursts of up to
// MAX_BURST beats and drives the shared FIFO write port combinationally.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int GW = gid_w(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST);
  localparam logic [GW-1:0] LAST_RST   = GW'(NUM_REQ - 1);

  arb_state_t    state_q, state_d;
  logic [GW-1:0] owner_q, owner_d;
  logic [GW-1:0] last_q, last_d;
  logic [BW-1:0] beats_q, beats_d;
  logic [BW-1:0] beats_inc;

  logic          found;
  logic [GW-1:0] winner;
  logic [GW-1:0] cur_id;
  logic          granted;
  logic          xfer;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_q),
    .found      (found),
    .winner     (winner)
  );

  // In IDLE the picker's winner is granted in the same cycle, so bursts chain
  // without a bubble.
  assign cur_id    = (state_q == OWN) ? owner_q : winner;
  assign granted   = (state_q == OWN) || found;
  assign xfer      = !rst && granted && bus.req_valid[cur_id] && !bus.fifo_full;
  assign beats_inc = beats_q + BW'(1);

  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_data_in = '0;
    bus.grant_valid  = 1'b0;
    bus.grant_id     = '0;
    if (!rst && granted) begin
      bus.grant_valid       = 1'b1;
      bus.grant_id          = cur_id;
      bus.req_ready[cur_id] = !bus.fifo_full;
      bus.fifo_wr_en        = xfer;
      bus.fifo_data_in      = bus.req_data[int'(cur_id)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beats_d = beats_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          if (xfer && (MAX_BURST == 1)) begin
            last_d = winner;
          end else begin
            // A stalled winner keeps ownership until it can transfer.
            state_d = OWN;
            owner_d = winner;
            beats_d = xfer ? BW'(1) : '0;
          end
        end
      end
      OWN: begin
        if (!bus.req_valid[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
          beats_d = '0;
        end else if (xfer) begin
          if (beats_inc == BURST_LAST) begin
            state_d = IDLE;
            last_d  = owner_q;
            beats_d = '0;
          end else begin
            beats_d = beats_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      beats_q <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beats_q <= beats_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter with a behavioural 16-deep FIFO model.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus_a ();
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus_b ();

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  logic [DW-1:0] pq [N][$];
  logic [DW-1:0] sb [$];
  int            glog [$];
  int            wcyc [$];
  int            cyc, fcnt, total, bad;
  bit            rd_en, sel;

  logic          o_wr, o_gv, o_full;
  logic [DW-1:0] o_data;
  logic [1:0]    o_gid;
  logic [N-1:0]  o_ready;

  task automatic drive();
    logic [DW-1:0] d;
    logic          v;
    for (int i = 0; i < N; i++) begin
      v = (pq[i].size() != 0);
      d = v ? pq[i][0] : '0;
      bus_a.req_valid[i]        = v;
      bus_b.req_valid[i]        = v;
      bus_a.req_data[i*DW +: DW] = d;
      bus_b.req_data[i*DW +: DW] = d;
    end
    bus_a.fifo_full = (fcnt >= DEPTH);
    bus_b.fifo_full = (fcnt >= DEPTH);
  endtask

  task automatic sample();
    o_wr    = sel ? bus_b.fifo_wr_en   : bus_a.fifo_wr_en;
    o_data  = sel ? bus_b.fifo_data_in : bus_a.fifo_data_in;
    o_gv    = sel ? bus_b.grant_valid  : bus_a.grant_valid;
    o_gid   = sel ? bus_b.grant_id     : bus_a.grant_id;
    o_ready = sel ? bus_b.req_ready    : bus_a.req_ready;
    o_full  = bus_a.fifo_full;
  endtask

  // One clock: observe at the falling edge, then advance producers and FIFO.
  task automatic cycle();
    logic [DW-1:0] exp;
    logic [N-1:0]  acc;
    int            r;
    @(negedge clk);
    sample();
    if (o_wr) begin
      glog.push_back(int'(o_gid));
      wcyc.push_back(cyc);
      total++;
      if (o_full !== 1'b0) begin
        bad++;
        $display("FAIL wr_while_full: fifo_wr_en=%b with fifo_full=%b, required no write", o_wr, o_full);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: data=%02h, required no write", o_data);
      end else begin
        exp = sb.pop_front();
        if (o_data !== exp) begin
          bad++;
          $display("FAIL write_data: got %02h, required %02h", o_data, exp);
        end
      end
    end
    for (int i = 0; i < N; i++) acc[i] = o_ready[i] && (pq[i].size() != 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(pq[i].pop_front());
    r    = (rd_en && fcnt > 0) ? 1 : 0;
    fcnt = fcnt + (o_wr ? 1 : 0) - r;
    cyc++;
    drive();
    #1;
  endtask

  task automatic run_for(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
  endtask

  task automatic clear_all();
    rst = 1'b1;
    for (int i = 0; i < N; i++) pq[i].delete();
    sb.delete();
    glog.delete();
    wcyc.delete();
    fcnt  = 0;
    rd_en = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) pq[i].push_back(DW'(8'h50 + i));
    drive();
    for (int pass = 0; pass < 2; pass++) begin
      #2;
      total++;
      if (bus_a.req_ready !== 4'b0 || bus_a.fifo_wr_en !== 1'b0 || bus_a.grant_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctrl_a: ready=%b wr=%b gv=%b, required 0", bus_a.req_ready, bus_a.fifo_wr_en, bus_a.grant_valid);
      end
      total++;
      if (bus_a.grant_id !== 2'd0 || bus_a.fifo_data_in !== 8'h00) begin
        bad++;
        $display("FAIL reset_data_a: gid=%0d data=%02h, required 0", bus_a.grant_id, bus_a.fifo_data_in);
      end
      total++;
      if (bus_b.req_ready !== 4'b0 || bus_b.fifo_wr_en !== 1'b0 || bus_b.grant_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_ctrl_b: ready=%b wr=%b gv=%b, required 0", bus_b.req_ready, bus_b.fifo_wr_en, bus_b.grant_valid);
      end
      @(posedge clk);
      #1;
    end
    clear_all();
  endtask

  task automatic test_priority();
    int exp;
    sel = 1'b0;
    clear_all();
    for (int n = 0; n < 4; n++) begin
      pq[0].push_back(DW'(8'hA0 + n));
      pq[2].push_back(DW'(8'hC0 + n));
    end
    for (int n = 0; n < 4; n++) sb.push_back(DW'(8'hA0 + n));
    for (int n = 0; n < 4; n++) sb.push_back(DW'(8'hC0 + n));
    drive();
    #1;
    run_for(20);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL prio_timeout: %0d beats pending, required 0", sb.size());
    end
    for (int k = 0; k < 8; k++) begin
      exp = (k < 4) ? 0 : 2;
      total++;
      if (glog.size() <= k || glog[k] !== exp) begin
        bad++;
        $display("FAIL prio_gid[%0d]: got %0d, required %0d", k, (glog.size() > k) ? glog[k] : -1, exp);
      end
    end
    total++;
    if (wcyc.size() != 8 || (wcyc[7] - wcyc[0]) != 7) begin
      bad++;
      $display("FAIL prio_no_bubble: %0d writes, required 8 on consecutive cycles", wcyc.size());
    end
  endtask

  task automatic test_round_robin();
    sel = 1'b0;
    clear_all();
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 8; n++) pq[i].push_back(DW'(8'h10 * i + n));
    for (int i = 0; i < N; i++)
      for (int n = 0; n < 4; n++) sb.push_back(DW'(8'h10 * i + n));
    drive();
    #1;
    run_for(40);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL rr_timeout: %0d beats pending, required 0", sb.size());
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (glog.size() <= k || glog[k] !== k / 4) begin
        bad++;
        $display("FAIL rr_gid[%0d]: got %0d, required %0d", k, (glog.size() > k) ? glog[k] : -1, k / 4);
      end
    end
    total++;
    if (wcyc.size() != 16 || (wcyc[15] - wcyc[0]) != 15) begin
      bad++;
      $display("FAIL rr_continuous: %0d writes, required 16 back to back", wcyc.size());
    end
    sample();
    total++;
    if (o_wr !== 1'b0 || o_gv !== 1'b1 || o_gid !== 2'd0) begin
      bad++;
      $display("FAIL rr_full_lock: wr=%b gv=%b gid=%0d, required wr=0 gv=1 gid=0", o_wr, o_gv, o_gid);
    end
  endtask

  task automatic test_backpressure();
    int exp;
    sel = 1'b0;
    clear_all();
    fcnt = 14;
    for (int n = 0; n < 4; n++) pq[1].push_back(DW'(8'h31 + n));
    pq[2].push_back(8'h41);
    pq[2].push_back(8'h42);
    for (int n = 0; n < 4; n++) sb.push_back(DW'(8'h31 + n));
    sb.push_back(8'h41);
    sb.push_back(8'h42);
    drive();
    #1;
    cycle();
    cycle();
    for (int s = 0; s < 2; s++) begin
      sample();
      total++;
      if (o_wr !== 1'b0 || o_ready !== 4'b0 || o_gv !== 1'b1 || o_gid !== 2'd1) begin
        bad++;
        $display("FAIL bp_stall%0d: wr=%b ready=%b gv=%b gid=%0d, required wr=0 ready=0 gv=1 gid=1",
                 s, o_wr, o_ready, o_gv, o_gid);
      end
      if (s == 0) cycle();
    end
    rd_en = 1'b1;
    run_for(20);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL bp_timeout: %0d beats pending, required 0", sb.size());
    end
    for (int k = 0; k < 6; k++) begin
      exp = (k < 4) ? 1 : 2;
      total++;
      if (glog.size() <= k || glog[k] !== exp) begin
        bad++;
        $display("FAIL bp_gid[%0d]: got %0d, required %0d", k, (glog.size() > k) ? glog[k] : -1, exp);
      end
    end
  endtask

  task automatic test_early_release();
    int exp;
    sel = 1'b0;
    clear_all();
    pq[1].push_back(8'h51);
    pq[1].push_back(8'h52);
    pq[3].push_back(8'h71);
    pq[3].push_back(8'h72);
    sb.push_back(8'h51);
    sb.push_back(8'h52);
    sb.push_back(8'h71);
    sb.push_back(8'h72);
    drive();
    #1;
    run_for(20);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL er_timeout: %0d beats pending, required 0", sb.size());
    end
    for (int k = 0; k < 4; k++) begin
      exp = (k < 2) ? 1 : 3;
      total++;
      if (glog.size() <= k || glog[k] !== exp) begin
        bad++;
        $display("FAIL er_gid[%0d]: got %0d, required %0d", k, (glog.size() > k) ? glog[k] : -1, exp);
      end
    end
    total++;
    if (wcyc.size() != 4 || (wcyc[2] - wcyc[1]) != 2 || (wcyc[1] - wcyc[0]) != 1) begin
      bad++;
      $display("FAIL er_bubble: %0d writes, required exactly one idle cycle before req3", wcyc.size());
    end
  endtask

  task automatic test_async_reset();
    sel = 1'b0;
    clear_all();
    for (int n = 0; n < 4; n++) pq[2].push_back(DW'(8'hC0 + n));
    sb.push_back(8'hC0);
    sb.push_back(8'hC1);
    drive();
    #1;
    run_for(10);
    sample();
    total++;
    if (o_wr !== 1'b1 || o_data !== 8'hC2 || o_gid !== 2'd2) begin
      bad++;
      $display("FAIL ar_pre: wr=%b data=%02h gid=%0d, required wr=1 data=c2 gid=2", o_wr, o_data, o_gid);
    end
    rst = 1'b1;
    #1;
    sample();
    total++;
    if (o_ready !== 4'b0 || o_wr !== 1'b0 || o_gv !== 1'b0) begin
      bad++;
      $display("FAIL ar_drop: ready=%b wr=%b gv=%b, required 0", o_ready, o_wr, o_gv);
    end
    total++;
    if (o_gid !== 2'd0 || o_data !== 8'h00) begin
      bad++;
      $display("FAIL ar_drop_data: gid=%0d data=%02h, required 0", o_gid, o_data);
    end
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      for (int n = 0; n < 4; n++) pq[i].push_back(DW'(8'h10 * i + n));
    end
    sb.delete();
    glog.delete();
    wcyc.delete();
    for (int n = 0; n < 4; n++) sb.push_back(DW'(n));
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    run_for(20);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL ar_timeout: %0d beats pending, required 0", sb.size());
    end
    total++;
    if (glog.size() < 1 || glog[0] !== 0) begin
      bad++;
      $display("FAIL ar_first_grant: got %0d, required 0", (glog.size() > 0) ? glog[0] : -1);
    end
  endtask

  task automatic test_burst1();
    int order [6] = '{0, 1, 2, 3, 0, 1};
    sel = 1'b1;
    clear_all();
    pq[0].push_back(8'h00);
    pq[0].push_back(8'h01);
    pq[1].push_back(8'h10);
    pq[1].push_back(8'h11);
    pq[2].push_back(8'h20);
    pq[3].push_back(8'h30);
    sb.push_back(8'h00);
    sb.push_back(8'h10);
    sb.push_back(8'h20);
    sb.push_back(8'h30);
    sb.push_back(8'h01);
    sb.push_back(8'h11);
    drive();
    #1;
    run_for(20);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL b1_timeout: %0d beats pending, required 0", sb.size());
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (glog.size() <= k || glog[k] !== order[k]) begin
        bad++;
        $display("FAIL b1_gid[%0d]: got %0d, required %0d", k, (glog.size() > k) ? glog[k] : -1, order[k]);
      end
    end
    total++;
    if (wcyc.size() != 6 || (wcyc[5] - wcyc[0]) != 5) begin
      bad++;
      $display("FAIL b1_no_bubble: %0d writes, required 6 back to back", wcyc.size());
    end
    sel = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    fcnt  = 0;
    rd_en = 1'b0;
    sel   = 1'b0;
    rst   = 1'b1;
    test_reset();
    test_priority();
    test_round_robin();
    test_backpressure();
    test_early_release();
    test_async_reset();
    test_burst1();
    clear_all();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
